// File: rtl/test_seq_pkg.sv
// Shared types and default sizing for the test sequencer.
package test_seq_pkg;

   // Sequencer states (see table in test_sequencer).
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_HOLD = 3'd2,
      ST_RUN  = 3'd3,
      ST_DONE = 3'd4
   } seq_state_e;

   localparam int DEF_INSTR_W    = 16;
   localparam int DEF_DEPTH      = 16;
   localparam int DEF_RST_CYCLES = 2;
   localparam int DEF_MAX_CYCLES = 1024;
   localparam int DEF_CNT_W      = 16;

   // Bits needed to represent the value itself (0..value), never less than 1.
   function automatic int bits_for(input int value);
      return (value < 2) ? 1 : $clog2(value + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at LIMIT instead of wrapping.
module sat_counter #(
   parameter int W     = 16,
   parameter int LIMIT = 1024
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: clear wins, otherwise step while below the limit.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != W'(LIMIT))) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/test_sequencer.sv
// Loads a program into instruction memory, holds the core in reset, then runs it
// until it halts or the cycle budget is spent.
//
// state | meaning
// IDLE  | waiting for start; core held in reset
// LOAD  | accepting program words, each written straight to imem
// HOLD  | program loaded; core kept in reset for RST_CYCLES cycles
// RUN   | core released; cycle budget counting
// DONE  | core halted or timed out; flags and cycle count frozen
module test_sequencer
   import test_seq_pkg::*;
#(
   parameter int INSTR_W    = DEF_INSTR_W,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int RST_CYCLES = DEF_RST_CYCLES,
   parameter int MAX_CYCLES = DEF_MAX_CYCLES,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic [INSTR_W-1:0] ld_data,
   input  logic               ld_last,
   input  logic               core_halt,
   output logic               core_reset,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               busy,
   output logic               done,
   output logic               timeout,
   output logic [CNT_W-1:0]   cycle_count,
   output logic [ADDR_W:0]    load_count
);

   localparam int HOLD_W = bits_for(RST_CYCLES);

   seq_state_e        state_q;
   seq_state_e        state_d;
   logic [ADDR_W:0]   load_count_q;
   logic [ADDR_W:0]   load_count_d;
   logic              done_q;
   logic              done_d;
   logic              timeout_q;
   logic              timeout_d;

   logic              cyc_clr;
   logic              cyc_en;
   logic              hold_clr;
   logic              hold_en;
   logic [HOLD_W-1:0] hold_cnt;

   // Run-cycle budget counter; saturation keeps it from wrapping past the budget.
   sat_counter #(
      .W     (CNT_W),
      .LIMIT (MAX_CYCLES)
   ) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cyc_clr),
      .en    (cyc_en),
      .count (cycle_count)
   );

   // Core-reset hold timer; idles at zero outside HOLD so every entry starts fresh.
   sat_counter #(
      .W     (HOLD_W),
      .LIMIT (RST_CYCLES)
   ) u_hold_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (hold_clr),
      .en    (hold_en),
      .count (hold_cnt)
   );

   // Next-state, counter control and per-state outputs.
   always_comb begin
      state_d      = state_q;
      load_count_d = load_count_q;
      done_d       = done_q;
      timeout_d    = timeout_q;
      ld_ready     = 1'b0;
      core_reset   = 1'b1;
      busy         = 1'b0;
      imem_we      = 1'b0;
      cyc_clr      = 1'b0;
      cyc_en       = 1'b0;
      hold_clr     = 1'b1;
      hold_en      = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d      = ST_LOAD;
               load_count_d = '0;
               done_d       = 1'b0;
               timeout_d    = 1'b0;
               cyc_clr      = 1'b1;
            end
         end

         ST_LOAD: begin
            ld_ready = 1'b1;
            busy     = 1'b1;
            if (ld_valid) begin
               imem_we      = 1'b1;
               load_count_d = load_count_q + (ADDR_W+1)'(1);
               // Leaving on the DEPTH-th word keeps writes inside the memory.
               if (ld_last || (load_count_q == (ADDR_W+1)'(DEPTH - 1))) begin
                  state_d = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            busy     = 1'b1;
            hold_clr = 1'b0;
            hold_en  = 1'b1;
            if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            core_reset = 1'b0;
            busy       = 1'b1;
            cyc_en     = 1'b1;
            // This cycle's increment brings the count to the budget; a halt in
            // the same cycle is a clean finish, not a timeout.
            if (core_halt) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               timeout_d = 1'b0;
            end else if (cycle_count >= CNT_W'(MAX_CYCLES - 1)) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               timeout_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         load_count_q <= '0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         load_count_q <= load_count_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
      end
   end

   assign imem_addr  = load_count_q[ADDR_W-1:0];
   assign imem_wdata = ld_data;
   assign load_count = load_count_q;
   assign done       = done_q;
   assign timeout    = timeout_q;

endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 Parameter INSTR_W, default 16: instruction word width loaded into instruction memory.
REQ-002 Parameter DEPTH, default 16: instruction memory words; ADDR_W = clog2(DEPTH).
REQ-003 Parameter RST_CYCLES, default 2: cycles core_reset is held high before the core runs (minimum 1).
REQ-004 Parameter MAX_CYCLES, default 1024: run-cycle budget before timeout.
REQ-005 Parameter CNT_W, default 16: cycle_count width; MAX_CYCLES SHALL fit in CNT_W.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to begin load-and-run.
REQ-009 ld_valid  in  1  host program word valid.
REQ-010 ld_ready  out  1  sequencer accepts a program word.
REQ-011 ld_data  in  INSTR_W  program word.
REQ-012 ld_last  in  1  marks the final program word, qualified by ld_valid.
REQ-013 core_halt  in  1  processor signals end of program.
REQ-014 core_reset  out  1  active-high reset to the processor.
REQ-015 imem_we, imem_addr, imem_wdata  out  1/ADDR_W/INSTR_W  instruction memory write port.
REQ-016 busy, done, timeout  out  1 each  status flags.
REQ-017 cycle_count  out  CNT_W  cycles spent in RUN.
REQ-018 load_count  out  ADDR_W+1  program words accepted.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, HOLD, RUN, DONE.
REQ-020 IDLE: ld_ready=0, core_reset=1, busy=0; start -> LOAD, clearing load_count, cycle_count, done and timeout.
REQ-021 LOAD: ld_ready=1, busy=1; a handshake (ld_valid & ld_ready) SHALL write ld_data at address load_count in the same cycle (imem_we = handshake, imem_addr = load_count[ADDR_W-1:0], imem_wdata = ld_data, zero latency) and increment load_count.
REQ-022 LOAD exits to HOLD after the handshake carrying ld_last, or after the DEPTH-th handshake, whichever comes first; no write SHALL occur beyond address DEPTH-1.
REQ-023 ld_valid without ld_last SHALL never be dropped or double-written; ld_valid=0 keeps LOAD waiting indefinitely.
REQ-024 HOLD: core_reset=1, ld_ready=0, busy=1, for exactly RST_CYCLES cycles, then RUN.
REQ-025 RUN: core_reset=0, busy=1; cycle_count increments by 1 every RUN cycle, saturating, never wrapping.
REQ-026 RUN -> DONE when core_halt=1 (done=1, timeout=0), or when cycle_count reaches MAX_CYCLES (done=1, timeout=1).
REQ-027 core_halt and budget exhaustion in the same cycle: halt wins, timeout=0.
REQ-028 DONE: core_reset=1, busy=0, done and timeout held, cycle_count frozen; start -> LOAD with counters and flags cleared.
REQ-029 start in LOAD, HOLD or RUN SHALL be ignored; core_halt outside RUN SHALL be ignored.
REQ-030 imem_we SHALL be 0 in every state except LOAD.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE from any state, including mid-LOAD and mid-RUN.
REQ-032 Reset values: core_reset=1, ld_ready=0, imem_we=0, imem_addr=0, busy=0, done=0, timeout=0, cycle_count=0, load_count=0.
REQ-033 reset SHALL take priority over start, ld_valid and core_halt in the same cycle.

Structure
REQ-034 Shared package test_seq_pkg SHALL hold the state enum and the default parameter constants.
REQ-035 One sub-module, sat_counter (parametrised width, clear, enable, saturate-at-limit), SHALL implement cycle_count and the HOLD timer.
REQ-036 The block SHALL be synthesisable, with no delays or system tasks; the simulation top instantiates it between the stimulus and the processor.

Verification
REQ-037 Reset, start, 3 words 0x1111/0x2222/0x3333 with ld_last on the third -> writes at addr 0,1,2, load_count=3, core_reset high 2 cycles, then RUN.
REQ-038 core_halt pulsed on the 10th RUN cycle -> done=1, timeout=0, cycle_count=10, core_reset=1.
REQ-039 MAX_CYCLES=8, core_halt never asserted -> done=1, timeout=1, cycle_count=8.
REQ-040 DEPTH=4, 6 words streamed without ld_last -> exactly 4 writes (addr 0-3), ld_ready low after the 4th, load_count=4.
REQ-041 reset asserted mid-RUN at cycle 5 -> next cycle IDLE, core_reset=1, cycle_count=0, busy=0; a following start reloads correctly.
REQ-042 core_halt and budget exhaustion coincident at cycle MAX_CYCLES -> done=1, timeout=0.
